booth_seq_multiplier: RTL and testbench
=======================================

# booth_seq_multiplier

Parametrised, multi-cycle radix-2 Booth multiplier with a start/done handshake and a per-operation signed/unsigned mode. It is the sequential successor to the team's combinational 8x8 signed Booth multiplier. It trades single-cycle latency for one add/shift stage per cycle, so wide operands stay cheap. It sits behind any datapath controller that issues one multiply at a time and waits for completion.

## Interface
- WIDTH, 8, operand width in bits (legal range 4..32); product is 2*WIDTH bits.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- sgn  input  1  1 = operands are two's complement, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- ready  output  1  block can accept start this cycle (state IDLE or DONE).
- busy  output  1  iteration in progress (state RUN).
- done  output  1  one-cycle pulse: c holds a new result.
- c  output  2*WIDTH  product; signed or unsigned per latched sgn; held until the next result.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE after the last iteration.
  - DONE -> RUN on start, otherwise DONE -> IDLE.
- Accept (start && ready):
  - Extend a and b to WIDTH+1 bits: sign-extend if sgn=1, zero-extend if sgn=0. This gives M and Q.
  - Clear accumulator A. A is WIDTH+2 bits, one guard bit against overflow when M is the most negative value.
  - Clear Booth bit q_1 to 0 and clear the iteration counter.
- RUN, per cycle, with the pair {Q[0], q_1}:
  - 01: A = A + sext(M).
  - 10: A = A - sext(M).
  - 00 or 11: no add.
  - Then arithmetic-shift {A, Q, q_1} right by one.
  - Increment the counter.
- Iteration count is always WIDTH+1, for both modes. In signed mode the extra iteration is redundant but harmless, so a single count applies to both modes.
- On the final iteration edge:
  - c <= low 2*WIDTH bits of the shifted {A, Q}.
  - State moves to DONE.
- start while busy=1 is ignored. Operands and sgn are not re-sampled and the running result is not disturbed.
- a, b and sgn may change freely after the accept edge.
- Reset, at any time including mid-RUN:
  - state = IDLE, c = 0, done = 0, busy = 0, ready = 1.
  - All internal registers are cleared.
  - No result is produced for the aborted operation.

## Timing
- Edge 0 accepts start. busy=1 from edge 0 through edge WIDTH+1.
- Edges 1..WIDTH+1 are the iterations. c updates on edge WIDTH+1.
- done=1 and ready=1 during the cycle after edge WIDTH+1.
- Latency from the start-sampling edge to done high is WIDTH+1 edges. For WIDTH=8 that is 9 edges.
- Throughput: start may be asserted in the DONE cycle, so back-to-back issue achieves one result every WIDTH+2 cycles.
  - done still pulses in that DONE cycle.
  - c keeps the previous result until the new final iteration.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Reset values: ready=1, busy=0, done=0, c=0.

## Test plan
- WIDTH=8, sgn=1, a=0xF0, b=0xF0 (-16*-16): c=0x0100 (256); done pulses exactly 9 edges after start is sampled; busy is high for exactly 9 cycles.
- WIDTH=8, sgn=1, a=0x95, b=0x20 (-107*32): c=0xF2A0 (-3424). Same operands with sgn=0 (149*32): c=0x12A0 (4768).
- Extremes, WIDTH=8:
  - sgn=0, 0xFF*0xFF: c=0xFE01.
  - sgn=1, 0x80*0x80: c=0x4000.
  - sgn=1, 0x80*0x7F: c=0xC080.
  - sgn=1, 0x07*0x00: c=0x0000.
- Handshake: pulse start again mid-RUN with different a and b: the new operands are ignored, the original result appears on schedule, and done is a single pulse. Assert start in the DONE cycle: the second result appears WIDTH+1 edges later.
- Reset mid-RUN (edge 4): next cycle c=0, busy=0, done=0, ready=1, and no done pulse follows. A new start then completes with the correct product.
- WIDTH=16 instance, sgn=1, a=0x8000, b=0x8000: c=0x40000000; done 17 edges after start. Randomised sweep in both modes checked against a behavioural multiply.

Source files
------------

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier
//   Multi-cycle radix-2 Booth multiplier. Each operation runs one add/shift
//   step per cycle. A per-operation sgn input selects signed or unsigned
//   operands.
//
//   Ports
//     clk    rising-edge clock
//     rst    synchronous, active-high reset
//     start  request, taken only while ready=1
//     sgn    1 = two's complement operands, 0 = unsigned (sampled with start)
//     a, b   multiplicand / multiplier (sampled with start)
//     ready  block can accept start this cycle
//     busy   iteration in progress
//     done   one-cycle pulse, c holds a new result
//     c      2*WIDTH-bit product, held until the next result
//
//   state | meaning
//   IDLE  | waiting for start, c holds last result
//   RUN   | one Booth add/shift step per cycle, WIDTH+1 steps
//   DONE  | result valid pulse; a new start may be taken here
module booth_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   c
);

    localparam int CNT_W = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Operands are extended by one bit so a single Booth recoding handles
    // both signed and unsigned inputs.
    logic [WIDTH:0]   m_reg;
    logic [WIDTH:0]   q_reg;
    // One guard bit above M so subtracting the most negative M cannot overflow.
    logic [WIDTH+1:0] acc;
    logic             q_1;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last_iter;
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] acc_sh;
    logic [WIDTH:0]   q_sh;

    // One Booth step: add/subtract, then arithmetic right shift of {A, Q, q_1}.
    always_comb begin
        m_ext = {m_reg[WIDTH], m_reg};
        case ({q_reg[0], q_1})
            2'b01:   sum = acc + m_ext;
            2'b10:   sum = acc - m_ext;
            default: sum = acc;
        endcase
        acc_sh = {sum[WIDTH+1], sum[WIDTH+1:1]};
        q_sh   = {sum[0], q_reg[WIDTH:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode only the state register, so there is no path from the
    // inputs to the outputs.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_iter = 1'b0;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CNT_W'(WIDTH)) begin
                    last_iter = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg <= '0;
            q_reg <= '0;
            acc   <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
            c     <= '0;
        end else if (accept) begin
            m_reg <= sgn ? {a[WIDTH-1], a} : {1'b0, a};
            q_reg <= sgn ? {b[WIDTH-1], b} : {1'b0, b};
            acc   <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_sh;
            q_reg <= q_sh;
            q_1   <= q_reg[0];
            cnt   <= cnt + CNT_W'(1);
            if (last_iter) begin
                c <= {acc_sh[WIDTH-2:0], q_sh};
            end
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
module tb_booth_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        start8, start16;
    logic        sgn;
    logic [15:0] a, b;
    logic        ready8, busy8, done8;
    logic        ready16, busy16, done16;
    logic [15:0] c8;
    logic [31:0] c16;

    int n_checks = 0;
    int n_err    = 0;
    logic [63:0] prev_c [2];

    booth_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .sgn   (sgn),
        .a     (a[7:0]),
        .b     (b[7:0]),
        .ready (ready8),
        .busy  (busy8),
        .done  (done8),
        .c     (c8)
    );

    booth_seq_multiplier #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
        .ready (ready16),
        .busy  (busy16),
        .done  (done16),
        .c     (c16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer multiply of the operands interpreted per sgn.
    function automatic logic [63:0] model(input int w, input bit s,
                                          input logic [63:0] x, input logic [63:0] y);
        longint xm, ym, p;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        xm = longint'(x & mask);
        ym = longint'(y & mask);
        if (s && x[w-1]) xm = xm - (longint'(1) << w);
        if (s && y[w-1]) ym = ym - (longint'(1) << w);
        p = xm * ym;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic logic [63:0] cur_c(input bit w16);
        return w16 ? 64'(c16) : 64'(c8);
    endfunction

    // Issues one operation (in the current cycle if ready), follows it to
    // done and checks latency, busy length, held c and the product.
    task automatic run(input bit w16, input bit s, input logic [15:0] aa,
                       input logic [15:0] bb, input bit poke);
        int w;
        int n;
        int nbusy;
        logic [63:0] exp;
        w = w16 ? 16 : 8;
        n = 0;
        nbusy = 0;
        exp = model(w, s, 64'(aa), 64'(bb));
        while (!(w16 ? ready16 : ready8) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_start", 64'(w16 ? ready16 : ready8), 64'd1);
        sgn = s; a = aa; b = bb;
        if (w16) start16 = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sgn = ~s;
        n = 0;
        while (!(w16 ? done16 : done8) && n < 3 * w) begin
            if (w16 ? busy16 : busy8) nbusy++;
            if (n == w) check("c_hold", cur_c(w16), prev_c[w16]);
            if (poke && n == 3) begin
                a = ~aa; b = aa ^ 16'h5a5a;
                if (w16) start16 = 1'b1; else start8 = 1'b1;
            end
            if (poke && n == 4) begin
                start8 = 1'b0; start16 = 1'b0;
            end
            @(posedge clk); #1; n++;
        end
        check("latency", 64'(n), 64'(w + 1));
        check("busy_cycles", 64'(nbusy), 64'(w + 1));
        check("product", cur_c(w16), exp);
        prev_c[w16] = exp;
    endtask

    initial begin
        int seen;
        rst = 1'b1; start8 = 1'b0; start16 = 1'b0; sgn = 1'b0; a = '0; b = '0;
        prev_c[0] = '0; prev_c[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", 64'(ready8), 64'd1);
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_c", 64'(c8), 64'd0);
        check("rst_c16", 64'(c16), 64'd0);

        // Directed vectors, issued back-to-back from the DONE cycle.
        run(0, 1, 16'h00F0, 16'h00F0, 0);
        check("vec_f0f0", 64'(c8), 64'h0100);
        run(0, 1, 16'h0095, 16'h0020, 0);
        check("vec_signed", 64'(c8), 64'hF2A0);
        run(0, 0, 16'h0095, 16'h0020, 0);
        check("vec_unsigned", 64'(c8), 64'h12A0);
        run(0, 0, 16'h00FF, 16'h00FF, 0);
        check("vec_ffff_u", 64'(c8), 64'hFE01);
        run(0, 1, 16'h0080, 16'h0080, 0);
        check("vec_8080_s", 64'(c8), 64'h4000);
        run(0, 1, 16'h0080, 16'h007F, 0);
        check("vec_807f_s", 64'(c8), 64'hC080);
        run(0, 1, 16'h0007, 16'h0000, 0);
        check("vec_zero", 64'(c8), 64'h0000);

        // Start pulsed mid-RUN must be ignored; done is a single pulse.
        @(posedge clk); #1;
        run(0, 1, 16'h00B3, 16'h0041, 1);
        @(posedge clk); #1;
        check("done_single", 64'(done8), 64'd0);
        check("idle_ready", 64'(ready8), 64'd1);
        check("c_after_idle", 64'(c8), prev_c[0]);

        // Reset on edge 4 of a run.
        sgn = 1'b1; a = 16'h0033; b = 16'h0055; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_c", 64'(c8), 64'd0);
        check("mid_rst_busy", 64'(busy8), 64'd0);
        check("mid_rst_done", 64'(done8), 64'd0);
        check("mid_rst_ready", 64'(ready8), 64'd1);
        prev_c[0] = '0; prev_c[1] = '0;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done8) seen++;
        end
        check("no_done_after_rst", 64'(seen), 64'd0);
        run(0, 1, 16'h00C5, 16'h003A, 0);

        // Wide instance.
        run(1, 1, 16'h8000, 16'h8000, 0);
        check("vec16_8000", 64'(c16), 64'h40000000);
        run(1, 0, 16'hFFFF, 16'hFFFF, 0);

        // Randomised sweep in both modes on both instances.
        for (int i = 0; i < 24; i++) begin
            run(0, 1'($urandom), 16'($urandom), 16'($urandom), 0);
            if (($urandom % 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        for (int i = 0; i < 16; i++) begin
            run(1, 1'($urandom), 16'($urandom), 16'($urandom), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
